// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART command path.
//   byte_t          raw 8-bit character from the UART receiver
//   nibble_t        4-bit value held by each downstream nibble register
//   parser_state_t  frame parser state (IDLE / DATA / END)
//   ascii2nib       ASCII hex character -> nibble, with a validity flag
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [3:0] nibble_t;

    // Frame delimiters.
    localparam byte_t ASCII_COLON = 8'h3A;
    localparam byte_t ASCII_CR    = 8'h0D;

    // Bounds of the three accepted hex character ranges.
    localparam byte_t ASCII_0     = 8'h30;
    localparam byte_t ASCII_9     = 8'h39;
    localparam byte_t ASCII_UA    = 8'h41;
    localparam byte_t ASCII_UF    = 8'h46;
    localparam byte_t ASCII_LA    = 8'h61;
    localparam byte_t ASCII_LF    = 8'h66;

    // Offsets that map each range onto 0..15.
    localparam byte_t OFS_DIGIT   = 8'h30;
    localparam byte_t OFS_UPPER   = 8'h37;
    localparam byte_t OFS_LOWER   = 8'h57;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        END  = 2'd2
    } parser_state_t;

    // Decode one ASCII hex character. valid is 0 for anything outside
    // '0'-'9', 'A'-'F', 'a'-'f'; the returned nibble is then 0.
    function automatic nibble_t ascii2nib(input byte_t ch, output logic valid);
        byte_t diff;
        diff  = 8'h00;
        valid = 1'b0;
        if ((ch >= ASCII_0) && (ch <= ASCII_9)) begin
            diff  = ch - OFS_DIGIT;
            valid = 1'b1;
        end else if ((ch >= ASCII_UA) && (ch <= ASCII_UF)) begin
            diff  = ch - OFS_UPPER;
            valid = 1'b1;
        end else if ((ch >= ASCII_LA) && (ch <= ASCII_LF)) begin
            diff  = ch - OFS_LOWER;
            valid = 1'b1;
        end else begin
            diff  = 8'h00;
            valid = 1'b0;
        end
        return diff[3:0];
    endfunction

endpackage

// File: rtl/hex_nibble_parser_decode.sv
// -----------------------------------------------------------------------------
// ascii_hex_decode
// Combinational ASCII-hex character decoder, a thin wrapper over ascii2nib so
// the decode can be reused and tested on its own.
//   byte_in  in   8   character to decode
//   nib      out  4   decoded value (0 when not a hex character)
//   is_hex   out  1   1 when byte_in is '0'-'9', 'A'-'F' or 'a'-'f'
// -----------------------------------------------------------------------------
module ascii_hex_decode
    import uart_pkg::*;
(
    input  byte_t   byte_in,
    output nibble_t nib,
    output logic    is_hex
);

    nibble_t nib_s;
    logic    is_hex_s;

    // Decode the incoming character through the shared package helper.
    always_comb begin
        is_hex_s = 1'b0;
        nib_s    = ascii2nib(byte_in, is_hex_s);
    end

    assign nib    = nib_s;
    assign is_hex = is_hex_s;

endmodule

// File: rtl/hex_nibble_parser.sv
// -----------------------------------------------------------------------------
// hex_nibble_parser
// Parses ASCII-hex frames ':' + N_NIBBLES hex chars + CR arriving from the
// UART receiver and feeds the nibble register bank: one write strobe per
// character, then a frame_done pulse (well-formed frame) or a frame_err pulse
// (bad character or bad length). Every response is registered and appears one
// clock after the rx_valid cycle that caused it.
//   clk         in   1          system clock, rising edge
//   rst         in   1          asynchronous active-low reset
//   rx_data     in   8          received byte, qualified by rx_valid
//   rx_valid    in   1          one-cycle strobe for rx_data
//   nib_out     out  4          decoded nibble, shared by all registers
//   nib_wr_en   out  N_NIBBLES  one-hot write enable, bit i = i-th character
//   frame_done  out  1          pulse: complete, well-formed frame
//   frame_err   out  1          pulse: frame aborted
//   busy        out  1          high while a frame is in progress (DATA/END)
// -----------------------------------------------------------------------------
module hex_nibble_parser
    import uart_pkg::*;
#(
    parameter int    N_NIBBLES  = 4,
    parameter byte_t START_CHAR = ASCII_COLON,
    parameter byte_t END_CHAR   = ASCII_CR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [3:0]           nib_out,
    output logic [N_NIBBLES-1:0] nib_wr_en,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 busy
);

    // A single-nibble frame still needs a 1-bit index.
    localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

    localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_NIBBLES - 1);
    localparam logic [N_NIBBLES-1:0] WR_NONE  = {N_NIBBLES{1'b0}};
    localparam logic [N_NIBBLES-1:0] WR_ONE   = N_NIBBLES'(1'b1);

    parser_state_t          state_r;
    parser_state_t          state_nx_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_nx_s;
    nibble_t                nib_r;
    nibble_t                nib_nx_s;
    logic [N_NIBBLES-1:0]   wr_en_r;
    logic [N_NIBBLES-1:0]   wr_en_nx_s;
    logic                   done_r;
    logic                   done_nx_s;
    logic                   err_r;
    logic                   err_nx_s;
    logic                   busy_r;
    logic                   busy_nx_s;

    nibble_t                dec_nib_s;
    logic                   dec_hex_s;

    ascii_hex_decode u_decode (
        .byte_in (rx_data),
        .nib     (dec_nib_s),
        .is_hex  (dec_hex_s)
    );

    // Next-state, index and output computation; only rx_valid cycles advance.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        nib_nx_s   = nib_r;
        wr_en_nx_s = WR_NONE;
        done_nx_s  = 1'b0;
        err_nx_s   = 1'b0;

        if (rx_valid) begin
            case (state_r)
                IDLE: begin
                    // Line noise between frames is dropped silently.
                    if (rx_data == START_CHAR) begin
                        state_nx_s = DATA;
                        idx_nx_s   = IDX_ZERO;
                    end else begin
                        state_nx_s = IDLE;
                        idx_nx_s   = IDX_ZERO;
                    end
                end

                DATA: begin
                    if (dec_hex_s) begin
                        nib_nx_s   = dec_nib_s;
                        wr_en_nx_s = WR_ONE << idx_r;
                        if (idx_r == IDX_LAST) begin
                            state_nx_s = END;
                            idx_nx_s   = idx_r;
                        end else begin
                            state_nx_s = DATA;
                            idx_nx_s   = idx_r + IDX_ONE;
                        end
                    end else if (rx_data == START_CHAR) begin
                        // A fresh start mid-frame restarts collection.
                        err_nx_s   = 1'b1;
                        state_nx_s = DATA;
                        idx_nx_s   = IDX_ZERO;
                    end else begin
                        // Early terminator or any other non-hex byte.
                        err_nx_s   = 1'b1;
                        state_nx_s = IDLE;
                        idx_nx_s   = IDX_ZERO;
                    end
                end

                END: begin
                    if (rx_data == END_CHAR) begin
                        done_nx_s  = 1'b1;
                        state_nx_s = IDLE;
                        idx_nx_s   = IDX_ZERO;
                    end else if (rx_data == START_CHAR) begin
                        err_nx_s   = 1'b1;
                        state_nx_s = DATA;
                        idx_nx_s   = IDX_ZERO;
                    end else begin
                        // Too many characters before the terminator.
                        err_nx_s   = 1'b1;
                        state_nx_s = IDLE;
                        idx_nx_s   = IDX_ZERO;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to IDLE and flag the frame.
                    err_nx_s   = 1'b1;
                    state_nx_s = IDLE;
                    idx_nx_s   = IDX_ZERO;
                end
            endcase
        end else begin
            state_nx_s = state_r;
            idx_nx_s   = idx_r;
        end

        busy_nx_s = (state_nx_s == DATA) || (state_nx_s == END);
    end

    // State, index and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            nib_r   <= 4'h0;
            wr_en_r <= WR_NONE;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            nib_r   <= nib_nx_s;
            wr_en_r <= wr_en_nx_s;
            done_r  <= done_nx_s;
            err_r   <= err_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    assign nib_out    = nib_r;
    assign nib_wr_en  = wr_en_r;
    assign frame_done = done_r;
    assign frame_err  = err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_hex_nibble_parser.sv
// -----------------------------------------------------------------------------
// tb_hex_nibble_parser
// Self-checking bench: a frame-level model predicts every output each cycle,
// and per-scenario logs of writes/pulses are checked against literal values.
// -----------------------------------------------------------------------------
module tb_hex_nibble_parser;

    localparam int N = 4;

    typedef logic [7:0] ent_t;   // {nib_wr_en, nib_out} of one write
    typedef ent_t ent_q_t[$];

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [3:0]   nib_out;
    logic [N-1:0] nib_wr_en;
    logic         frame_done;
    logic         frame_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    hex_nibble_parser #(.N_NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .nib_out    (nib_out),
        .nib_wr_en  (nib_wr_en),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- frame-level model ----------------
    bit           m_in_frame = 1'b0;
    int           m_cnt      = 0;     // hex characters collected so far
    logic [3:0]   e_nib      = 4'h0;
    logic [N-1:0] e_wr       = '0;
    logic         e_done     = 1'b0;
    logic         e_err      = 1'b0;

    function automatic int hexval(input logic [7:0] c);
        string up = "0123456789ABCDEF";
        string lo = "0123456789abcdef";
        for (int v = 0; v < 16; v++)
            if (c == up[v] || c == lo[v]) return v;
        return -1;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0; m_cnt = 0;
        e_nib = 4'h0; e_wr = '0; e_done = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] b);
        int v;
        e_wr = '0; e_done = 1'b0; e_err = 1'b0;
        v = hexval(b);
        if (!m_in_frame) begin
            if (b == 8'h3A) begin m_in_frame = 1'b1; m_cnt = 0; end
        end else if (m_cnt < N) begin
            if (v >= 0) begin
                e_nib = v[3:0]; e_wr[m_cnt] = 1'b1; m_cnt++;
            end else if (b == 8'h3A) begin
                e_err = 1'b1; m_cnt = 0;
            end else begin
                e_err = 1'b1; m_in_frame = 1'b0; m_cnt = 0;
            end
        end else begin
            if (b == 8'h0D) begin
                e_done = 1'b1; m_in_frame = 1'b0; m_cnt = 0;
            end else if (b == 8'h3A) begin
                e_err = 1'b1; m_cnt = 0;
            end else begin
                e_err = 1'b1; m_in_frame = 1'b0; m_cnt = 0;
            end
        end
    endtask

    // ---------------- per-cycle compare + event log ----------------
    ent_t wr_log[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;

    always @(negedge clk) begin
        n_checks++;
        if (nib_out !== e_nib || nib_wr_en !== e_wr || frame_done !== e_done ||
            frame_err !== e_err || busy !== m_in_frame) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t: got nib=%h wr=%b done=%b err=%b busy=%b, want nib=%h wr=%b done=%b err=%b busy=%b",
                     $time, nib_out, nib_wr_en, frame_done, frame_err, busy,
                     e_nib, e_wr, e_done, e_err, m_in_frame);
        end
        if (nib_wr_en !== '0) wr_log.push_back({nib_wr_en, nib_out});
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            e_wr = '0; e_done = 1'b0; e_err = 1'b0;
        end
    endtask

    // Called one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        model_step(b);
        idle(gap);
    endtask

    task automatic send_str(input string s, input bit gappy);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], gappy ? ((i * 7) % 21) : 0);
    endtask

    task automatic clear_log();
        wr_log.delete(); done_cnt = 0; err_cnt = 0;
    endtask

    task automatic check_log(input string name, input ent_q_t exp, input int exp_done, input int exp_err);
        check({name, ".writes"}, wr_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
            check($sformatf("%s.write%0d", name, i), {24'h0, wr_log[i]}, {24'h0, exp[i]});
        check({name, ".done"}, done_cnt, exp_done);
        check({name, ".err"}, err_cnt, exp_err);
        clear_log();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();
        idle(3);
        check("reset.nib",  {28'h0, nib_out}, 32'h0);
        check("reset.wr",   {28'h0, nib_wr_en}, 32'h0);
        check("reset.busy", {31'h0, busy}, 32'h0);
        rst = 1'b1;
        idle(2);

        // 1: reset mid-DATA with idx=2
        send_str(":12", 1'b0);
        check("mid.busy", {31'h0, busy}, 32'h1);
        check("mid.nib",  {28'h0, nib_out}, 32'h2);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("async_rst.nib",  {28'h0, nib_out}, 32'h0);
        check("async_rst.busy", {31'h0, busy}, 32'h0);
        check("async_rst.pulses", {29'h0, frame_done, frame_err, |nib_wr_en}, 32'h0);
        idle(2);
        rst = 1'b1;
        clear_log();
        send_str(":ABCD", 1'b0); send_byte(8'h0D, 0); idle(2);
        check_log("after_reset", '{8'h1A, 8'h2B, 8'h4C, 8'h8D}, 1, 0);

        // 2: good frame
        send_str(":1aF0", 1'b0); send_byte(8'h0D, 0); idle(2);
        check_log("good", '{8'h11, 8'h2A, 8'h4F, 8'h80}, 1, 0);
        check("good.nib_hold", {28'h0, nib_out}, 32'h0);

        // 3: bad character
        send_str(":12G", 1'b0); idle(2);
        check_log("badchar", '{8'h11, 8'h22}, 0, 1);
        check("badchar.busy", {31'h0, busy}, 32'h0);
        check("badchar.nib_hold", {28'h0, nib_out}, 32'h2);

        // 4: short and long frames
        send_str(":12", 1'b0); send_byte(8'h0D, 0); idle(2);
        check_log("short", '{8'h11, 8'h22}, 0, 1);
        send_str(":12345", 1'b0); idle(2);
        check_log("long", '{8'h11, 8'h22, 8'h43, 8'h84}, 0, 1);
        check("long.busy", {31'h0, busy}, 32'h0);
        send_byte(8'h0D, 2);  // stray CR in IDLE is ignored
        check_log("stray_cr", '{}, 0, 0);

        // 5: resync on second ':'
        send_str(":12:ABCD", 1'b0); send_byte(8'h0D, 0); idle(2);
        check_log("resync", '{8'h11, 8'h22, 8'h1A, 8'h2B, 8'h4C, 8'h8D}, 1, 1);

        // 5b: ':' in END state restarts the frame
        send_str(":9876:5432", 1'b0); send_byte(8'h0D, 0); idle(2);
        check_log("end_resync", '{8'h19, 8'h28, 8'h47, 8'h86, 8'h15, 8'h24, 8'h43, 8'h82}, 1, 1);

        // 6: noise in IDLE, then gaps inside a frame
        send_str("xyz", 1'b1); idle(2);
        check_log("noise", '{}, 0, 0);
        check("noise.busy", {31'h0, busy}, 32'h0);
        send_str(":1aF0", 1'b1); send_byte(8'h0D, 5); idle(2);
        check_log("gaps", '{8'h11, 8'h2A, 8'h4F, 8'h80}, 1, 0);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
